// File: rtl/adder_arb_pkg.sv
// Shared constants and state encoding for the two-requester adder arbiter.
package adder_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/adder_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on contention the side not granted last time wins.
module rr_pick2
    import adder_arb_pkg::*;
(
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic gnt,
    output logic any
);

    logic gnt_s;

    // Grant selection with alternation on contention
    always_comb begin
        gnt_s = ID_REQ0;
        if (v0 && v1) begin
            gnt_s = ~last;
        end else if (v1) begin
            gnt_s = ID_REQ1;
        end else begin
            gnt_s = ID_REQ0;
        end
    end

    assign gnt = gnt_s;
    assign any = v0 | v1;

endmodule

// File: rtl/ripple.sv
// N-bit ripple-carry adder shared by the arbiter; carry out is bit N of the sum.
module ripple #(
    parameter int N = 6
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s,
    output logic         c
);

    logic [N:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]         = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign c = carry_s[N];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one ripple adder between two valid/ready requesters.
// Optional grant counters cnt0/cnt1 are built when ADDER_ARB_STATS_EN is defined.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N = 6
`ifdef ADDER_ARB_STATS_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [N-1:0]     req0_a,
    input  logic [N-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [N-1:0]     req1_a,
    input  logic [N-1:0]     req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [N-1:0]     resp_s,
    output logic             resp_c,
    output logic             resp_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    state_e       state_r;
    state_e       state_s;
    logic [N-1:0] a_r;
    logic [N-1:0] b_r;
    logic         id_r;
    logic         last_grant_r;
    logic         gnt_s;
    logic         any_s;
    logic         hs_s;
    logic [N-1:0] sum_s;
    logic         carry_s;

    rr_pick2 u_pick (
        .v0   (req0_valid),
        .v1   (req1_valid),
        .last (last_grant_r),
        .gnt  (gnt_s),
        .any  (any_s)
    );

    ripple #(.N(N)) u_ripple (
        .a (a_r),
        .b (b_r),
        .s (sum_s),
        .c (carry_s)
    );

    // In IDLE the picked requester is always a valid one, so any_s means a handshake
    assign hs_s = (state_r == S_IDLE) && any_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and request ready generation
    always_comb begin
        state_s    = state_r;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (any_s) begin
                    state_s = S_BUSY;
                    if (gnt_s == ID_REQ1) begin
                        req1_ready = 1'b1;
                    end else begin
                        req0_ready = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_BUSY: state_s = S_DONE;
            S_DONE: begin
                if (resp_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Operand capture, result register and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r          <= {N{1'b0}};
            b_r          <= {N{1'b0}};
            id_r         <= ID_REQ0;
            last_grant_r <= ID_REQ1;
            resp_valid   <= 1'b0;
            resp_s       <= {N{1'b0}};
            resp_c       <= 1'b0;
            resp_id      <= ID_REQ0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (hs_s) begin
                        a_r          <= (gnt_s == ID_REQ1) ? req1_a : req0_a;
                        b_r          <= (gnt_s == ID_REQ1) ? req1_b : req0_b;
                        id_r         <= gnt_s;
                        last_grant_r <= gnt_s;
                    end
                end
                S_BUSY: begin
                    resp_s     <= sum_s;
                    resp_c     <= carry_s;
                    resp_id    <= id_r;
                    resp_valid <= 1'b1;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: resp_valid <= 1'b0;
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;

    // Saturating accepted-operation counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_r <= {CNT_W{1'b0}};
            cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (hs_s && (gnt_s == ID_REQ0) && (cnt0_r != CNT_MAX)) begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end
            if (hs_s && (gnt_s == ID_REQ1) && (cnt1_r != CNT_MAX)) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`endif

endmodule
